// File: rtl/id_stage_if.sv
// ID/EX bundle presented by the decode stage to the execute stage.
interface id_stage_if;
    logic        id_valid;
    logic [31:0] id_pc_plus4;
    logic [31:0] id_rs1_data;
    logic [31:0] id_rs2_data;
    logic [31:0] id_imm;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic [3:0]  id_alu_op;
    logic        id_alu_src_imm;
    logic        id_mem_read;
    logic        id_mem_write;
    logic        id_reg_write;
    logic        id_branch;
    logic        id_branch_ne;
    logic        id_illegal;

    modport master (
        output id_valid, id_pc_plus4, id_rs1_data, id_rs2_data, id_imm,
        output id_rs1, id_rs2, id_rd, id_alu_op, id_alu_src_imm,
        output id_mem_read, id_mem_write, id_reg_write, id_branch,
        output id_branch_ne, id_illegal
    );

    modport slave (
        input id_valid, id_pc_plus4, id_rs1_data, id_rs2_data, id_imm,
        input id_rs1, id_rs2, id_rd, id_alu_op, id_alu_src_imm,
        input id_mem_read, id_mem_write, id_reg_write, id_branch,
        input id_branch_ne, id_illegal
    );
endinterface

// File: rtl/id_stage.sv
// RV32I decode stage: register file, immediate/control decode,
// load-use hazard detection and the ID/EX pipeline register.
module id_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] if_pc_plus4,
    input  logic [31:0] if_instr,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    input  logic        flush,
    output logic        stall_out,
    id_stage_if.master  id
);
    typedef enum logic [3:0] {
        ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
        ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
        ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASSB = 4'd10
    } alu_op_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc_plus4;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [3:0]  alu_op;
        logic        alu_src_imm;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic        branch;
        logic        branch_ne;
        logic        illegal;
    } id_ex_t;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    logic [31:0] rf_q [32];
    logic [31:0] rf_d [32];
    id_ex_t      id_q, id_d, dec;

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rs1, rs2;
    logic [31:0] rs1_data, rs2_data;
    logic [31:0] imm_i, imm_s, imm_b, imm_u;
    logic        f7_base, f7_alt, alt, imm_ok, op_ok;
    logic        legal, rs1_used, rs2_used, hazard, ok;
    alu_op_e     alu_f3;

    assign opcode = if_instr[6:0];
    assign funct3 = if_instr[14:12];
    assign funct7 = if_instr[31:25];
    assign rs1    = if_instr[19:15];
    assign rs2    = if_instr[24:20];

    assign imm_i = {{20{if_instr[31]}}, if_instr[31:20]};
    assign imm_s = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
    assign imm_b = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                    if_instr[30:25], if_instr[11:8], 1'b0};
    assign imm_u = {if_instr[31:12], 12'b0};

    // Same-cycle writeback is forwarded so WB->ID needs no extra bypass.
    assign rs1_data = (rs1 == 5'd0) ? 32'd0 :
                      (wb_we && wb_rd == rs1) ? wb_data : rf_q[rs1];
    assign rs2_data = (rs2 == 5'd0) ? 32'd0 :
                      (wb_we && wb_rd == rs2) ? wb_data : rf_q[rs2];

    always_comb begin : rf_next
        rf_d = rf_q;
        if (wb_we && wb_rd != 5'd0) rf_d[wb_rd] = wb_data;
    end

    assign f7_base = (funct7 == 7'h00);
    assign f7_alt  = (funct7 == 7'h20);
    assign alt     = funct7[5] && (opcode == OPC_OP || funct3 == 3'b101);
    assign imm_ok  = (funct3 == 3'b001) ? f7_base :
                     (funct3 == 3'b101) ? (f7_base || f7_alt) : 1'b1;
    assign op_ok   = f7_base ||
                     (f7_alt && (funct3 == 3'b000 || funct3 == 3'b101));

    always_comb begin : alu_sel
        alu_f3 = ALU_ADD;
        unique case (funct3)
            3'b000: alu_f3 = alt ? ALU_SUB : ALU_ADD;
            3'b001: alu_f3 = ALU_SLL;
            3'b010: alu_f3 = ALU_SLT;
            3'b011: alu_f3 = ALU_SLTU;
            3'b100: alu_f3 = ALU_XOR;
            3'b101: alu_f3 = alt ? ALU_SRA : ALU_SRL;
            3'b110: alu_f3 = ALU_OR;
            3'b111: alu_f3 = ALU_AND;
        endcase
    end

    always_comb begin : decode
        dec          = '0;
        dec.pc_plus4 = if_pc_plus4;
        dec.rs1_data = rs1_data;
        dec.rs2_data = rs2_data;
        dec.rs1      = rs1;
        dec.rs2      = rs2;
        dec.rd       = if_instr[11:7];
        legal        = 1'b0;
        rs1_used     = 1'b0;
        rs2_used     = 1'b0;
        unique case (opcode)
            OPC_OP_IMM: begin
                legal           = imm_ok;
                rs1_used        = 1'b1;
                dec.imm         = imm_i;
                dec.alu_op      = alu_f3;
                dec.alu_src_imm = 1'b1;
                dec.reg_write   = 1'b1;
            end
            OPC_OP: begin
                legal         = op_ok;
                rs1_used      = 1'b1;
                rs2_used      = 1'b1;
                dec.alu_op    = alu_f3;
                dec.reg_write = 1'b1;
            end
            OPC_LOAD: begin
                legal           = (funct3 == 3'b010);
                rs1_used        = 1'b1;
                dec.imm         = imm_i;
                dec.alu_src_imm = 1'b1;
                dec.mem_read    = 1'b1;
                dec.reg_write   = 1'b1;
            end
            OPC_STORE: begin
                legal           = (funct3 == 3'b010);
                rs1_used        = 1'b1;
                rs2_used        = 1'b1;
                dec.imm         = imm_s;
                dec.alu_src_imm = 1'b1;
                dec.mem_write   = 1'b1;
            end
            OPC_BRANCH: begin
                legal         = (funct3[2:1] == 2'b00);
                rs1_used      = 1'b1;
                rs2_used      = 1'b1;
                dec.imm       = imm_b;
                dec.alu_op    = ALU_SUB;
                dec.branch    = 1'b1;
                dec.branch_ne = funct3[0];
            end
            OPC_LUI: begin
                legal           = 1'b1;
                dec.imm         = imm_u;
                dec.alu_op      = ALU_PASSB;
                dec.alu_src_imm = 1'b1;
                dec.reg_write   = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

    assign hazard = ex_mem_read && ex_rd != 5'd0 && legal && !flush &&
                    ((rs1_used && rs1 == ex_rd) ||
                     (rs2_used && rs2 == ex_rd));
    assign stall_out = hazard && !reset;
    assign ok = legal && !hazard && !flush;

    always_comb begin : id_next
        id_d         = dec;
        id_d.valid   = ok;
        id_d.illegal = !legal && (if_instr != 32'd0) && !flush;
        if (!ok) begin
            id_d.alu_op      = '0;
            id_d.alu_src_imm = 1'b0;
            id_d.mem_read    = 1'b0;
            id_d.mem_write   = 1'b0;
            id_d.reg_write   = 1'b0;
            id_d.branch      = 1'b0;
            id_d.branch_ne   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_q <= '0;
            rf_q <= '{default: '0};
        end else begin
            id_q <= id_d;
            rf_q <= rf_d;
        end
    end

    assign id.id_valid       = id_q.valid;
    assign id.id_pc_plus4    = id_q.pc_plus4;
    assign id.id_rs1_data    = id_q.rs1_data;
    assign id.id_rs2_data    = id_q.rs2_data;
    assign id.id_imm         = id_q.imm;
    assign id.id_rs1         = id_q.rs1;
    assign id.id_rs2         = id_q.rs2;
    assign id.id_rd          = id_q.rd;
    assign id.id_alu_op      = id_q.alu_op;
    assign id.id_alu_src_imm = id_q.alu_src_imm;
    assign id.id_mem_read    = id_q.mem_read;
    assign id.id_mem_write   = id_q.mem_write;
    assign id.id_reg_write   = id_q.reg_write;
    assign id.id_branch      = id_q.branch;
    assign id.id_branch_ne   = id_q.branch_ne;
    assign id.id_illegal     = id_q.illegal;
endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: driver pushes model expectations,
// monitor pops and compares one entry per clock.
module tb_id_stage;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] if_pc_plus4 = '0;
    logic [31:0] if_instr = '0;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        ex_mem_read = 1'b0;
    logic [4:0]  ex_rd = '0;
    logic        flush = 1'b0;
    logic        stall_out;

    id_stage_if idb ();

    id_stage dut (
        .clk(clk), .reset(reset), .if_pc_plus4(if_pc_plus4),
        .if_instr(if_instr), .wb_we(wb_we), .wb_rd(wb_rd),
        .wb_data(wb_data), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .flush(flush), .stall_out(stall_out), .id(idb)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        stall, valid, ill;
        logic [3:0]  alu;
        logic        srci, mr, mw, rw, br, bne;
        logic        c1, c2, ci;
        logic [31:0] pc, d1, d2, imm;
        logic [4:0]  rs1, rs2, rd;
    } exp_t;

    exp_t        oq[$];
    logic [31:0] regs [32];
    logic [31:0] pc = 32'h1000;
    logic        last_stall = 1'b0;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rdreg(input logic [4:0] a,
        input logic we, input logic [4:0] wrd, input logic [31:0] wd);
        if (a == 5'd0) return 32'd0;
        if (we && wrd == a) return wd;
        return regs[a];
    endfunction

    // Reference decode: mnemonic table in terms of funct3 -> ALU op number.
    function automatic exp_t model(input logic [31:0] ins, input logic we,
        input logic [4:0] wrd, input logic [31:0] wd, input logic emr,
        input logic [4:0] erd, input logic fl, input logic rst);
        exp_t e;
        int amap[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
        logic [6:0] op = ins[6:0];
        logic [2:0] f3 = ins[14:12];
        logic [6:0] f7 = ins[31:25];
        logic signed [31:0] s = ins;
        logic [31:0] t, imm;
        logic legal, u1, u2, hi, ok;
        logic srci, mr, mw, rw, br, bne;
        int alu;
        legal = 0; u1 = 0; u2 = 0; hi = 0; alu = 0; imm = 0;
        srci = 0; mr = 0; mw = 0; rw = 0; br = 0; bne = 0;
        case (op)
            7'h13: begin
                legal = (f3 == 1) ? (f7 == 0) :
                        (f3 == 5) ? (f7 == 0 || f7 == 7'h20) : 1'b1;
                alu = amap[f3] + ((f3 == 5 && f7 == 7'h20) ? 1 : 0);
                srci = 1; rw = 1; u1 = 1; hi = 1;
                imm = s >>> 20;
            end
            7'h33: begin
                legal = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
                alu = amap[f3] + ((f7 == 7'h20) ? 1 : 0);
                rw = 1; u1 = 1; u2 = 1;
            end
            7'h03: begin
                legal = (f3 == 2); srci = 1; mr = 1; rw = 1; u1 = 1; hi = 1;
                imm = s >>> 20;
            end
            7'h23: begin
                legal = (f3 == 2); srci = 1; mw = 1; u1 = 1; u2 = 1; hi = 1;
                t = s >>> 25;
                imm = (t << 5) | {27'd0, ins[11:7]};
            end
            7'h63: begin
                legal = (f3 < 2); alu = 1; br = 1; bne = (f3 == 1);
                u1 = 1; u2 = 1; hi = 1;
                t = s >>> 31;
                imm = (t << 12) | ({31'd0, ins[7]} << 11) |
                      ({26'd0, ins[30:25]} << 5) | ({28'd0, ins[11:8]} << 1);
            end
            7'h37: begin
                legal = 1; alu = 10; srci = 1; rw = 1; hi = 1;
                imm = ins & 32'hFFFFF000;
            end
            default: legal = 0;
        endcase
        e = '0;
        e.stall = !rst && !fl && legal && emr && erd != 0 &&
                  ((u1 && ins[19:15] == erd) || (u2 && ins[24:20] == erd));
        ok = !rst && legal && !fl && !e.stall;
        e.valid = ok;
        e.ill = !rst && !legal && ins != 0 && !fl;
        if (ok) begin
            e.alu = 4'(alu); e.srci = srci; e.mr = mr; e.mw = mw;
            e.rw = rw; e.br = br; e.bne = bne;
            e.c1 = u1; e.c2 = u2; e.ci = hi;
            e.pc = pc; e.imm = imm;
            e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
            e.d1 = rdreg(ins[19:15], we, wrd, wd);
            e.d2 = rdreg(ins[24:20], we, wrd, wd);
        end
        return e;
    endfunction

    task automatic step(input logic [31:0] ins, input logic we,
        input logic [4:0] wrd, input logic [31:0] wd, input logic emr,
        input logic [4:0] erd, input logic fl, input logic rst);
        exp_t e;
        @(negedge clk);
        reset = rst; if_instr = ins; if_pc_plus4 = pc;
        wb_we = we; wb_rd = wrd; wb_data = wd;
        ex_mem_read = emr; ex_rd = erd; flush = fl;
        e = model(ins, we, wrd, wd, emr, erd, fl, rst);
        oq.push_back(e);
        last_stall = e.stall;
        if (rst) foreach (regs[i]) regs[i] = '0;
        else if (we && wrd != 0) regs[wrd] = wd;
        if (!e.stall) pc = pc + 4;
        if (rst) begin
            #1;
            chk("async_reset", {idb.id_valid, idb.id_reg_write,
                idb.id_illegal, idb.id_rd, idb.id_imm, stall_out}, '0);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        int k = $urandom_range(0, 9);
        logic [31:0] r = $urandom;
        logic [4:0] rd = 5'($urandom_range(0, 7));
        logic [4:0] r1 = 5'($urandom_range(0, 7));
        logic [4:0] r2 = 5'($urandom_range(0, 7));
        logic [2:0] f3 = 3'($urandom);
        logic [6:0] f7;
        f7 = (r[1:0] == 0) ? r[31:25] : (r[2] ? 7'h20 : 7'h00);
        case (k)
            0, 1: return {f7, r[24:20], r1, f3, rd, 7'h13};
            2, 3: return {f7, r2, r1, f3, rd, 7'h33};
            4: return {r[31:20], r1, (r[3] ? 3'b010 : f3), rd, 7'h03};
            5: return {r[31:25], r2, r1, (r[3] ? 3'b010 : f3), r[11:7], 7'h23};
            6: return {r[31:25], r2, r1, (r[3] ? {2'b00, r[4]} : f3),
                       r[11:7], 7'h63};
            7: return {r[31:12], rd, 7'h37};
            8: return r;
            default: return 32'h0;
        endcase
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (oq.size() != 0) begin
                e = oq.pop_front();
                chk("stall", {63'd0, stall_out}, {63'd0, e.stall});
                chk("ctrl", {idb.id_valid, idb.id_illegal, idb.id_alu_op,
                    idb.id_alu_src_imm, idb.id_mem_read, idb.id_mem_write,
                    idb.id_reg_write, idb.id_branch, idb.id_branch_ne},
                    {e.valid, e.ill, e.alu, e.srci, e.mr, e.mw, e.rw,
                     e.br, e.bne});
                if (e.valid) begin
                    chk("pc_plus4", idb.id_pc_plus4, e.pc);
                    chk("indices", {idb.id_rs1, idb.id_rs2, idb.id_rd},
                        {e.rs1, e.rs2, e.rd});
                    if (e.c1) chk("rs1_data", idb.id_rs1_data, e.d1);
                    if (e.c2) chk("rs2_data", idb.id_rs2_data, e.d2);
                    if (e.ci) chk("imm", idb.id_imm, e.imm);
                end
            end
        end
    end

    initial begin : driver
        logic [31:0] cur;
        foreach (regs[i]) regs[i] = '0;
        step(32'h0, 0, 0, 0, 0, 0, 0, 1);
        step(32'h0, 0, 0, 0, 0, 0, 0, 1);
        step(32'h00100093, 0, 0, 0, 0, 0, 0, 0);
        step(32'h00418213, 1, 3, 32'hDEADBEEF, 0, 0, 0, 0);
        step(32'h0, 1, 0, 32'd5, 0, 0, 0, 0);
        step(32'h00000093, 0, 0, 0, 0, 0, 0, 0);
        step(32'h00108133, 0, 0, 0, 1, 1, 0, 0);
        step(32'h00108133, 0, 0, 0, 1, 1, 1, 0);
        step(32'h00108133, 0, 0, 0, 1, 0, 0, 0);
        step(32'hFE000EE3, 0, 0, 0, 0, 0, 0, 0);
        step(32'hFE101EE3, 0, 0, 0, 0, 0, 0, 0);
        step(32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0);
        step(32'h00000000, 0, 0, 0, 0, 0, 0, 0);
        cur = rand_instr();
        for (int n = 0; n < 600; n++) begin
            if (!last_stall) cur = rand_instr();
            step(cur, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                 $urandom, $urandom_range(0, 3) == 0,
                 5'($urandom_range(0, 7)), $urandom_range(0, 9) == 0, 0);
        end
        for (int i = 1; i < 32; i++)
            step(32'h00000033 | (32'(i) << 15) | (32'(i) << 20) |
                 (32'(i) << 7), 1, 5'(i), $urandom, 0, 0, 0, 0);
        step(32'h00100093, 0, 0, 0, 0, 0, 0, 0);
        step(32'h00100093, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 1; i < 32; i++)
            step(32'h00000333 | (32'(i) << 15) | (32'(32 - i) << 20),
                 0, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 200; n++) begin
            if (!last_stall) cur = rand_instr();
            step(cur, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                 $urandom, $urandom_range(0, 3) == 0,
                 5'($urandom_range(0, 7)), $urandom_range(0, 9) == 0, 0);
        end
        repeat (3) @(negedge clk);
        chk("drain", 64'(oq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
